// File: rtl/vga_draw_arbiter_pkg.sv
// Shared widths, screen geometry, FSM encoding and pixel payload for the VGA draw arbiter.
package vga_draw_arbiter_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_RELEASE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  // Index increment that wraps at n, which need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input int unsigned      n);
    logic [31:0] nxt;
    nxt = 32'(idx) + 32'd1;
    return (nxt >= n) ? '0 : IDX_W'(nxt);
  endfunction

endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// Rotating-priority search: first set request at or above rr_ptr, wrapping modulo NUM_REQ.
module vga_draw_arbiter_rr_pick
  import vga_draw_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid_c,
  output logic [IDX_W-1:0]   idx_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SUM_W-1:0]     sum;

  // Rotate so bit 0 is rr_ptr, then the lowest set bit wins.
  always_comb begin
    dbl     = {req, req};
    rot     = NUM_REQ'(dbl >> rr_ptr);
    valid_c = |rot;
    idx_c   = '0;
    sum     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = SUM_W'(rr_ptr) + SUM_W'(i);
        if (sum >= SUM_W'(NUM_REQ)) begin
          sum = sum - SUM_W'(NUM_REQ);
        end
        idx_c = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the VGA adapter pixel port: begin/done handshake per engine,
// watchdog reclaim of hung engines, and a grant-indexed pixel mux gated to WAIT_DONE.
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TIMEOUT_W = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         begin_draw,
  input  logic [NUM_REQ-1:0]         done,
  input  logic [NUM_REQ*X_W-1:0]     eng_x,
  input  logic [NUM_REQ*Y_W-1:0]     eng_y,
  input  logic [NUM_REQ*COLOR_W-1:0] eng_color,
  input  logic [NUM_REQ-1:0]         eng_drawEn,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [COLOR_W-1:0]         vga_color,
  output logic                       vga_plot,
  output logic                       busy,
  output logic [IDX_W-1:0]           grant_idx,
  output logic                       timeout_err
);

  localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   begin_draw_q, begin_draw_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  pixel_t               sel_px;
  logic                 sel_draw_en;
  logic                 sel_done;
  logic                 in_wait;
  logic                 wdog_max;

  vga_draw_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

  // Per-engine fields selected by the current grant.
  always_comb begin
    sel_px      = '0;
    sel_draw_en = 1'b0;
    sel_done    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        sel_px.x     = eng_x[i*X_W +: X_W];
        sel_px.y     = eng_y[i*Y_W +: Y_W];
        sel_px.color = eng_color[i*COLOR_W +: COLOR_W];
        sel_draw_en  = eng_drawEn[i];
        sel_done     = done[i];
      end
    end
  end

  assign in_wait  = (state_q == ST_WAIT_DONE);
  assign wdog_max = (wdog_q == WDOG_MAX);

  // Next-state and register updates; the watchdog bounds both WAIT_DONE and RELEASE.
  always_comb begin
    state_d       = state_q;
    begin_draw_d  = begin_draw_q;
    grant_idx_d   = grant_idx_q;
    rr_ptr_d      = rr_ptr_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_idx_d  = pick_idx;
          begin_draw_d = NUM_REQ'(1) << pick_idx;
          wdog_d       = '0;
          state_d      = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (sel_done) begin
          begin_draw_d = '0;
          wdog_d       = '0;
          state_d      = ST_RELEASE;
        end else if (wdog_max) begin
          begin_draw_d  = '0;
          timeout_err_d = 1'b1;
          wdog_d        = '0;
          state_d       = ST_RELEASE;
        end else begin
          wdog_d = wdog_q + TIMEOUT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!sel_done || wdog_max) begin
          if (wdog_max) begin
            timeout_err_d = 1'b1;
          end
          rr_ptr_d = wrap_inc(grant_idx_q, NUM_REQ);
          state_d  = ST_IDLE;
        end else begin
          wdog_d = wdog_q + TIMEOUT_W'(1);
        end
      end
      default: begin
        begin_draw_d = '0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      begin_draw_q  <= '0;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      begin_draw_q  <= begin_draw_d;
      grant_idx_q   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Pixels only reach the adapter while the granted engine owns the port.
  assign vga_x       = in_wait ? sel_px.x     : '0;
  assign vga_y       = in_wait ? sel_px.y     : '0;
  assign vga_color   = in_wait ? sel_px.color : '0;
  assign vga_plot    = in_wait & sel_draw_en;

  assign begin_draw  = begin_draw_q;
  assign busy        = (state_q != ST_IDLE);
  assign grant_idx   = grant_idx_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench: behavioural draw engines, expected grants queued by stimulus, checked by a monitor.
module tb_vga_draw_arbiter;

  localparam int NR   = 4;
  localparam int TW   = 8;
  localparam int WMAX = (1 << TW) - 1;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR-1:0]   begin_draw;
  logic [NR-1:0]   done;
  logic [NR*8-1:0] eng_x;
  logic [NR*7-1:0] eng_y;
  logic [NR*3-1:0] eng_color;
  logic [NR-1:0]   eng_drawEn;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_color;
  logic            vga_plot;
  logic            busy;
  logic [2:0]      grant_idx;
  logic            timeout_err;

  vga_draw_arbiter #(
    .NUM_REQ   (NR),
    .TIMEOUT_W (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .begin_draw  (begin_draw),
    .done        (done),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_color   (eng_color),
    .eng_drawEn  (eng_drawEn),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_color   (vga_color),
    .vga_plot    (vga_plot),
    .busy        (busy),
    .grant_idx   (grant_idx),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int dur;   // expected begin_draw high samples; 0 = not checked
    int gap;   // expected low samples since previous grant; -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   grant_cnt;

  int   len[NR];
  int   hold[NR];
  bit   hang[NR];
  int   cnt[NR];
  int   hold_cnt[NR];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Engines: done after len samples of begin_draw, held hold extra samples after begin drops.
  initial begin
    done = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (begin_draw[i]) begin
          if (!done[i]) begin
            cnt[i]++;
            if (!hang[i] && cnt[i] >= len[i]) begin
              done[i]     = 1'b1;
              hold_cnt[i] = hold[i];
            end
          end
        end else begin
          cnt[i] = 0;
          if (done[i]) begin
            if (hold_cnt[i] > 0) hold_cnt[i]--;
            else done[i] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops an expectation on every grant and models the adapter mux each cycle.
  initial begin
    logic [NR-1:0] prev_bd;
    exp_t          e;
    int            hi_cnt, lo_cnt, cur_idx, cur_dur;
    logic [18:0]   exp_vga, got_vga;
    prev_bd = '0; hi_cnt = 0; lo_cnt = 0; cur_idx = -1; cur_dur = 0;
    @(negedge reset);
    forever begin
      @(negedge clk);
      #3;
      chk("begin_onehot0", 32'($onehot0(begin_draw)), 32'd1);
      if (prev_bd == '0 && begin_draw != '0) begin
        grant_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant got=%b exp=none", begin_draw);
          cur_idx = -1;
          cur_dur = 0;
        end else begin
          e = exp_q.pop_front();
          chk("grant_begin", 32'(begin_draw), 32'(1 << e.idx));
          chk("grant_idx", 32'(grant_idx), 32'(e.idx));
          if (e.gap >= 0) chk("grant_gap", 32'(lo_cnt), 32'(e.gap));
          cur_idx = e.idx;
          cur_dur = e.dur;
        end
        hi_cnt = 0;
      end
      if (prev_bd != '0 && begin_draw == '0) begin
        if (cur_dur > 0) chk("draw_len", 32'(hi_cnt), 32'(cur_dur));
        lo_cnt = 0;
      end
      if (begin_draw != '0) hi_cnt++;
      else lo_cnt++;
      exp_vga = '0;
      if (begin_draw != '0 && cur_idx >= 0)
        exp_vga = {eng_drawEn[cur_idx], eng_x[cur_idx*8 +: 8],
                   eng_y[cur_idx*7 +: 7], eng_color[cur_idx*3 +: 3]};
      got_vga = {vga_plot, vga_x, vga_y, vga_color};
      chk("vga_mux", 32'(got_vga), 32'(exp_vga));
      prev_bd = begin_draw;
    end
  end

  task automatic wait_grants(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (grant_cnt >= target) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL wait_grant got=%0d exp=%0d", grant_cnt, target);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_idle got=busy exp=idle");
  endtask

  task automatic wait_fall(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (begin_draw == '0) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_fall got=%b exp=0", begin_draw);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_begin"}, 32'(begin_draw), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant_idx"}, 32'(grant_idx), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_vga"}, 32'({vga_plot, vga_x, vga_y, vga_color}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base, rel_cnt;
    checks = 0; failures = 0; grant_cnt = 0;
    reset = 1'b1; req = '0;
    eng_x = '0; eng_y = '0; eng_color = '0; eng_drawEn = '0;
    for (int i = 0; i < NR; i++) begin
      len[i] = 5; hold[i] = 0; hang[i] = 1'b0; cnt[i] = 0; hold_cnt[i] = 0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("rst");

    // 1: single engine, 10-cycle draw
    len[0] = 10;
    exp_q.push_back('{0, 10, -1});
    base = grant_cnt;
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    #1;
    chk("t1_begin_latency", 32'(begin_draw), 32'b0001);
    req = '0;
    wait_fall(40);
    chk("t1_release_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2: all engines requesting, round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++) len[i] = 5;
    exp_q.push_back('{0, 5, -1});
    exp_q.push_back('{1, 5, 2});
    exp_q.push_back('{2, 5, 2});
    exp_q.push_back('{3, 5, 2});
    exp_q.push_back('{0, 5, 2});
    base = grant_cnt;
    req = 4'b1111;
    wait_grants(base + 5, 200);
    req = '0;
    wait_idle(50);

    // 3: only the granted engine reaches the adapter (rr_ptr now 1, so engine 2 first)
    eng_x      = {8'd33, 8'd159, 8'd33, 8'd5};
    eng_y      = {7'd33, 7'd119, 7'd33, 7'd6};
    eng_color  = {3'd1, 3'd7, 3'd1, 3'd2};
    eng_drawEn = 4'b1111;
    len[2] = 8;
    len[0] = 4;
    exp_q.push_back('{2, 8, -1});
    exp_q.push_back('{0, 4, 2});
    base = grant_cnt;
    req = 4'b0101;
    wait_grants(base + 1, 20);
    #1;
    chk("t3_vga_x", 32'(vga_x), 32'd159);
    chk("t3_vga_y", 32'(vga_y), 32'd119);
    chk("t3_vga_color", 32'(vga_color), 32'd7);
    chk("t3_vga_plot", 32'(vga_plot), 32'd1);
    eng_drawEn[2] = 1'b0;
    @(negedge clk);
    #1;
    chk("t3_plot_gated", 32'(vga_plot), 32'd0);
    chk("t3_x_still_eng2", 32'(vga_x), 32'd159);
    wait_grants(base + 2, 30);
    req = '0;
    wait_idle(50);
    chk("t3_idle_plot", 32'(vga_plot), 32'd0);
    eng_drawEn = '0;

    // 4: engine 1 hangs, watchdog reclaims, engine 2 served next, error sticky
    do_reset();
    hang[1] = 1'b1;
    len[2]  = 3;
    exp_q.push_back('{1, WMAX + 1, -1});
    exp_q.push_back('{2, 3, 2});
    base = grant_cnt;
    req = 4'b0110;
    wait_grants(base + 1, 20);
    chk("t4_err_before", 32'(timeout_err), 32'd0);
    wait_fall(WMAX + 20);
    chk("t4_err_set", 32'(timeout_err), 32'd1);
    wait_grants(base + 2, 20);
    req = '0;
    hang[1] = 1'b0;
    wait_idle(50);
    chk("t4_err_sticky", 32'(timeout_err), 32'd1);

    // 5: reset mid-WAIT_DONE drops everything; held req re-grants from engine 0
    len[3] = 50;
    len[0] = 4;
    exp_q.push_back('{3, 0, -1});
    exp_q.push_back('{0, 4, -1});
    base = grant_cnt;
    req = 4'b1001;
    wait_grants(base + 1, 20);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("t5");
    wait_grants(base + 2, 20);
    req = '0;
    wait_idle(50);

    // 6: engine 1 holds done 20 cycles after begin drops; arbiter stays in RELEASE
    len[1]  = 4;
    hold[1] = 20;
    len[0]  = 4;
    exp_q.push_back('{1, 4, -1});
    exp_q.push_back('{0, 4, 22});
    base = grant_cnt;
    req = 4'b0011;
    wait_grants(base + 1, 20);
    wait_fall(20);
    rel_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (busy && begin_draw == '0) rel_cnt++;
    end
    chk("t6_release_hold", 32'(rel_cnt), 32'd20);
    wait_grants(base + 2, 20);
    req = '0;
    hold[1] = 0;
    wait_idle(50);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
